multicycle_cu: RTL and testbench

- Parametrised multi-cycle control unit for the LEGv8-subset datapath.
- Latches the instruction word on IL and sequences FETCH/DECODE/EXECUTE/MEM through a Moore FSM.
- Drives the same datapath control set as the single-cycle decoder, plus a memory ready handshake, illegal-opcode trap, bus timeout and a retired-instruction counter.
- Sits between program/data RAM, register file, ALU and PC.

---
 rtl/multicycle_cu.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// -----------------------------------------------------------------------------
// multicycle_cu -- multi-cycle control unit for the LEGv8-subset datapath.
//
// Latches the instruction word at the end of a successful fetch and steps the
// datapath through FETCH / DECODE / EXEC / MEM using a Moore FSM.  It also
// provides a memory-ready handshake with a bus timeout, a sticky trap for
// undecodable opcodes, and a counter of retired instructions.
//
// Ports
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   Inst                  instruction word from RAM, latched when IL is high
//   mem_ready             RAM completes the current access this cycle
//   zero_in               ALU zero flag of the operation in this cycle
//   DA, AA, BA            destination / A / B register addresses
//   Const                 zero-extended constant (imm12, DT_address or shamt)
//   FS                    ALU function select
//   PC_SEL                00 hold, 01 PC+4, 10 PC+offset
//   WR ... SFL            single-bit datapath controls
//   illegal, bus_err      sticky trap flags (cleared only by reset)
//   retired               number of completed instructions (wraps)
// -----------------------------------------------------------------------------
module multicycle_cu #(
   parameter int INST_W  = 32,
   parameter int RA_W    = 5,
   parameter int K_W     = 12,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INST_W-1:0] Inst,
   input  logic              mem_ready,
   input  logic              zero_in,
   output logic [RA_W-1:0]   DA,
   output logic [RA_W-1:0]   AA,
   output logic [RA_W-1:0]   BA,
   output logic [K_W-1:0]    Const,
   output logic [4:0]        FS,
   output logic [1:0]        PC_SEL,
   output logic              WR,
   output logic              WRR,
   output logic              RR,
   output logic              RCS,
   output logic              Reset,
   output logic              EN_ALU,
   output logic              EN_B,
   output logic              En_K,
   output logic              EN_ADDR_ALU,
   output logic              EN_ADDR_PC,
   output logic              IL,
   output logic              Cin,
   output logic              SFL,
   output logic              illegal,
   output logic              bus_err,
   output logic [CNT_W-1:0]  retired
);

   localparam logic [2:0] ST_RST    = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   // Instruction classes
   localparam logic [3:0] CL_BAD   = 4'd0;
   localparam logic [3:0] CL_R     = 4'd1;   // register-register ALU
   localparam logic [3:0] CL_I     = 4'd2;   // immediate ALU
   localparam logic [3:0] CL_SHIFT = 4'd3;   // LSL/LSR by shamt
   localparam logic [3:0] CL_LD    = 4'd4;
   localparam logic [3:0] CL_ST    = 4'd5;
   localparam logic [3:0] CL_B     = 4'd6;
   localparam logic [3:0] CL_CBZ   = 4'd7;
   localparam logic [3:0] CL_CBNZ  = 4'd8;

   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_EOR = 5'b01100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01001;
   localparam logic [4:0] FS_LSL = 5'b10000;
   localparam logic [4:0] FS_LSR = 5'b10100;

   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   logic [2:0]        state;
   logic [INST_W-1:0] ir;
   logic [WCNT_W-1:0] wait_cnt;
   logic [10:0]       op;
   logic [3:0]        cls;
   logic [4:0]        alu_fs;
   logic              alu_cin;
   logic              alu_sfl;
   logic              retire;
   logic              wait_expired;

   assign op           = ir[INST_W-1 -: 11];
   assign wait_expired = (wait_cnt == WCNT_W'(TIMEOUT - 1));

   // Opcode decode of the latched instruction (wildcards cover the shorter I/B/CB opcodes)
   always_comb begin
      cls     = CL_BAD;
      alu_fs  = FS_ADD;
      alu_cin = 1'b0;
      alu_sfl = 1'b0;
      casez (op)
         11'b10001011000: begin cls = CL_R; alu_fs = FS_ADD; end
         11'b10101011000: begin cls = CL_R; alu_fs = FS_ADD; alu_sfl = 1'b1; end
         11'b11001011000: begin cls = CL_R; alu_fs = FS_SUB; alu_cin = 1'b1; end
         11'b11101011000: begin cls = CL_R; alu_fs = FS_SUB; alu_cin = 1'b1; alu_sfl = 1'b1; end
         11'b10001010000: begin cls = CL_R; alu_fs = FS_AND; end
         11'b11101010000: begin cls = CL_R; alu_fs = FS_AND; alu_sfl = 1'b1; end
         11'b10101010000: begin cls = CL_R; alu_fs = FS_ORR; end
         11'b11001010000: begin cls = CL_R; alu_fs = FS_EOR; end
         11'b11010011011: begin cls = CL_SHIFT; alu_fs = FS_LSL; end
         11'b11010011010: begin cls = CL_SHIFT; alu_fs = FS_LSR; end
         11'b1001000100?: begin cls = CL_I; alu_fs = FS_ADD; end
         11'b1101000100?: begin cls = CL_I; alu_fs = FS_SUB; alu_cin = 1'b1; end
         11'b1001001000?: begin cls = CL_I; alu_fs = FS_AND; end
         11'b1011001000?: begin cls = CL_I; alu_fs = FS_ORR; end
         11'b1101001000?: begin cls = CL_I; alu_fs = FS_EOR; end
         11'b11111000010: cls = CL_LD;
         11'b11111000000: cls = CL_ST;
         11'b000101?????: cls = CL_B;
         11'b10110100???: cls = CL_CBZ;
         11'b10110101???: cls = CL_CBNZ;
         default:         cls = CL_BAD;
      endcase
   end

   // Register addresses and constant: pure functions of the latched instruction
   always_comb begin
      DA = RA_W'(ir[4:0]);
      AA = RA_W'(ir[9:5]);
      BA = RA_W'(ir[20:16]);
      Const = {K_W{1'b0}};
      case (cls)
         CL_I:          Const = K_W'(ir[21:10]);
         CL_SHIFT:      Const = K_W'(ir[15:10]);
         CL_LD, CL_ST:  begin Const = K_W'(ir[20:12]); BA = RA_W'(ir[4:0]); end
         CL_CBZ, CL_CBNZ: begin AA = RA_W'(5'd31); BA = RA_W'(ir[4:0]); end
         default:       Const = {K_W{1'b0}};
      endcase
   end

   // Moore control outputs; IL, WR (load) and PC_SEL (EXEC/MEM) also see mem_ready / zero_in
   always_comb begin
      FS = 5'b00000; PC_SEL = 2'b00;
      WR = 1'b0; WRR = 1'b0; RR = 1'b0; RCS = 1'b0; Reset = 1'b0;
      EN_ALU = 1'b0; EN_B = 1'b0; En_K = 1'b0; EN_ADDR_ALU = 1'b0;
      EN_ADDR_PC = 1'b0; IL = 1'b0; Cin = 1'b0; SFL = 1'b0;
      retire = 1'b0;
      case (state)
         ST_RST: Reset = 1'b1;
         ST_FETCH: begin
            EN_ADDR_PC = 1'b1; RCS = 1'b1; RR = 1'b1;
            IL = mem_ready;
         end
         ST_EXEC: begin
            case (cls)
               CL_R, CL_I, CL_SHIFT: begin
                  EN_ALU = 1'b1; WR = 1'b1; PC_SEL = 2'b01;
                  FS = alu_fs; Cin = alu_cin; SFL = alu_sfl;
                  EN_B = (cls == CL_R);
                  En_K = (cls != CL_R);
                  retire = 1'b1;
               end
               CL_LD, CL_ST: begin
                  FS = FS_ADD; En_K = 1'b1; EN_ADDR_ALU = 1'b1;
               end
               CL_B: begin
                  PC_SEL = 2'b10; retire = 1'b1;
               end
               CL_CBZ, CL_CBNZ: begin
                  EN_B = 1'b1; FS = FS_ADD; EN_ALU = 1'b1;
                  // take the branch when the register is zero (CBZ) or non-zero (CBNZ)
                  PC_SEL = (zero_in ^ (cls == CL_CBNZ)) ? 2'b10 : 2'b01;
                  retire = 1'b1;
               end
               default: retire = 1'b0;
            endcase
         end
         ST_MEM: begin
            EN_ADDR_ALU = 1'b1; RCS = 1'b1; En_K = 1'b1; FS = FS_ADD;
            RR  = (cls == CL_LD);
            WRR = (cls == CL_ST);
            if (mem_ready) begin
               WR = (cls == CL_LD);
               PC_SEL = 2'b01;
               retire = 1'b1;
            end else begin
               retire = 1'b0;
            end
         end
         default: retire = 1'b0;
      endcase
   end

   // State register, instruction latch, wait counter, trap flags and retire counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RST;
         ir       <= {INST_W{1'b0}};
         wait_cnt <= {WCNT_W{1'b0}};
         illegal  <= 1'b0;
         bus_err  <= 1'b0;
         retired  <= {CNT_W{1'b0}};
      end else begin
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end else begin
            retired <= retired;
         end
         case (state)
            ST_RST: begin
               state    <= ST_FETCH;
               wait_cnt <= {WCNT_W{1'b0}};
            end
            ST_FETCH, ST_MEM: begin
               if (mem_ready) begin
                  if (state == ST_FETCH) begin
                     ir    <= Inst;
                     state <= ST_DECODE;
                  end else begin
                     state <= ST_FETCH;
                  end
                  wait_cnt <= {WCNT_W{1'b0}};
               end else if (wait_expired) begin
                  bus_err  <= 1'b1;
                  state    <= ST_HALT;
                  wait_cnt <= {WCNT_W{1'b0}};
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            ST_DECODE: begin
               if (cls == CL_BAD) begin
                  illegal <= 1'b1;
                  state   <= ST_HALT;
               end else begin
                  state   <= ST_EXEC;
               end
               wait_cnt <= {WCNT_W{1'b0}};
            end
            ST_EXEC: begin
               if ((cls == CL_LD) || (cls == CL_ST)) begin
                  state <= ST_MEM;
               end else begin
                  state <= ST_FETCH;
               end
               wait_cnt <= {WCNT_W{1'b0}};
            end
            ST_HALT: state <= ST_HALT;
            // unreachable encodings park safely until reset
            default: state <= ST_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_cu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_cu -- self-checking bench for multicycle_cu.
// Each cycle the expected control word is queued when inputs are driven and
// popped / compared on the falling edge; sticky flags, addresses, constants and
// the retire counter are checked against bench-computed constants.
// -----------------------------------------------------------------------------
module tb_multicycle_cu;

   logic        clk;
   logic        rst_n;
   logic [31:0] Inst;
   logic        mem_ready;
   logic        zero_in;
   logic [4:0]  DA, AA, BA;
   logic [11:0] Const;
   logic [4:0]  FS;
   logic [1:0]  PC_SEL;
   logic WR, WRR, RR, RCS, Reset, EN_ALU, EN_B, En_K, EN_ADDR_ALU, EN_ADDR_PC, IL, Cin, SFL;
   logic        illegal, bus_err;
   logic [31:0] retired;

   multicycle_cu dut (
      .clk(clk), .rst_n(rst_n), .Inst(Inst), .mem_ready(mem_ready), .zero_in(zero_in),
      .DA(DA), .AA(AA), .BA(BA), .Const(Const), .FS(FS), .PC_SEL(PC_SEL),
      .WR(WR), .WRR(WRR), .RR(RR), .RCS(RCS), .Reset(Reset), .EN_ALU(EN_ALU),
      .EN_B(EN_B), .En_K(En_K), .EN_ADDR_ALU(EN_ADDR_ALU), .EN_ADDR_PC(EN_ADDR_PC),
      .IL(IL), .Cin(Cin), .SFL(SFL), .illegal(illegal), .bus_err(bus_err),
      .retired(retired)
   );

   // control word bit map: {Reset, IL, EN_ADDR_PC, RCS, RR, WRR, WR, EN_ALU, EN_B, En_K, EN_ADDR_ALU, Cin, SFL, PC_SEL[1:0], FS[4:0]}
   localparam logic [19:0] K_RESET = 20'h80000;
   localparam logic [19:0] K_IL    = 20'h40000;
   localparam logic [19:0] K_APC   = 20'h20000;
   localparam logic [19:0] K_RCS   = 20'h10000;
   localparam logic [19:0] K_RR    = 20'h08000;
   localparam logic [19:0] K_WRR   = 20'h04000;
   localparam logic [19:0] K_WR    = 20'h02000;
   localparam logic [19:0] K_ALU   = 20'h01000;
   localparam logic [19:0] K_B     = 20'h00800;
   localparam logic [19:0] K_K     = 20'h00400;
   localparam logic [19:0] K_AALU  = 20'h00200;
   localparam logic [19:0] K_CIN   = 20'h00100;
   localparam logic [19:0] K_SFL   = 20'h00080;
   localparam logic [19:0] K_POFF  = 20'h00040;
   localparam logic [19:0] K_P4    = 20'h00020;
   localparam logic [19:0] F_ADD   = 20'h00008;
   localparam logic [19:0] F_SUB   = 20'h00009;
   localparam logic [19:0] F_LSL   = 20'h00010;
   localparam logic [19:0] K_FETCH = K_APC | K_RCS | K_RR;
   localparam logic [19:0] K_LDMEM = K_AALU | K_RCS | K_K | F_ADD | K_RR;

   localparam logic [31:0] I_ADDI = 32'h91001441;
   localparam logic [31:0] I_SUBS = {11'h758, 5'd5, 6'd0, 5'd4, 5'd3};
   localparam logic [31:0] I_LSL  = {11'h69B, 5'd0, 6'd3, 5'd2, 5'd1};
   localparam logic [31:0] I_LDUR = {11'h7C2, 9'd16, 2'b00, 5'd2, 5'd7};
   localparam logic [31:0] I_STUR = {11'h7C0, 9'd8, 2'b00, 5'd2, 5'd7};
   localparam logic [31:0] I_CBZ  = {8'hB4, 19'd4, 5'd9};
   localparam logic [31:0] I_CBNZ = {8'hB5, 19'd4, 5'd9};
   localparam logic [31:0] I_B    = {6'b000101, 26'd8};
   localparam logic [31:0] I_BAD  = {11'h7FF, 21'd0};

   typedef struct {
      string       tag;
      logic [19:0] ctrl;
   } exp_t;

   exp_t        sb[$];
   int          n_vec;
   int          n_err;
   logic [19:0] ctrl_obs;

   assign ctrl_obs = {Reset, IL, EN_ADDR_PC, RCS, RR, WRR, WR, EN_ALU, EN_B, En_K,
                      EN_ADDR_ALU, Cin, SFL, PC_SEL, FS};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: drive inputs, queue expected controls, compare at negedge, land at posedge+1
   task automatic cyc(input logic rdy, input logic z, input logic [19:0] exp, input string tag);
      exp_t e;
      mem_ready = rdy;
      zero_in   = z;
      e.tag  = tag;
      e.ctrl = exp;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, 32'(ctrl_obs), 32'(e.ctrl));
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_dec(input logic [31:0] ins, input string nm);
      Inst = ins;
      cyc(1'b1, 1'b0, K_FETCH | K_IL, {nm, " fetch"});
      Inst = 32'hDEAD_BEEF;   // IR must keep the latched word
      cyc(1'b1, 1'b0, 20'h0, {nm, " decode"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; Inst = 32'h0; mem_ready = 1'b0; zero_in = 1'b0;
      @(posedge clk); #1;
      chk("reset ctrl", 32'(ctrl_obs), 32'(K_RESET));
      chk("reset retired", retired, 32'd0);
      chk("reset flags", {30'd0, illegal, bus_err}, 32'd0);
      rst_n = 1'b1;
      cyc(1'b1, 1'b0, K_RESET, "rst state");

      // ADDI X1,X2,#5 with mem_ready high throughout
      fetch_dec(I_ADDI, "addi");
      chk("addi retired pre", retired, 32'd0);
      cyc(1'b1, 1'b0, K_ALU | K_WR | K_K | F_ADD | K_P4, "addi exec");
      chk("addi retired", retired, 32'd1);
      chk("addi DA", 32'(DA), 32'd1);
      chk("addi AA", 32'(AA), 32'd2);
      chk("addi Const", 32'(Const), 32'd5);

      // SUBS X3,X4,X5
      fetch_dec(I_SUBS, "subs");
      cyc(1'b1, 1'b0, K_ALU | K_WR | K_B | F_SUB | K_CIN | K_SFL | K_P4, "subs exec");
      chk("subs BA", 32'(BA), 32'd5);
      chk("subs DA", 32'(DA), 32'd3);
      chk("subs AA", 32'(AA), 32'd4);

      // LSL X1,X2,#3
      fetch_dec(I_LSL, "lsl");
      cyc(1'b1, 1'b0, K_ALU | K_WR | K_K | F_LSL | K_P4, "lsl exec");
      chk("lsl Const", 32'(Const), 32'd3);
      chk("lsl retired", retired, 32'd3);

      // LDUR X7,[X2,#16] with three not-ready MEM cycles
      fetch_dec(I_LDUR, "ldur");
      cyc(1'b1, 1'b0, K_K | K_AALU | F_ADD, "ldur exec");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, K_LDMEM, "ldur mem wait");
      chk("ldur retired wait", retired, 32'd3);
      cyc(1'b1, 1'b0, K_LDMEM | K_WR | K_P4, "ldur mem ready");
      chk("ldur retired", retired, 32'd4);
      chk("ldur DA", 32'(DA), 32'd7);
      chk("ldur Const", 32'(Const), 32'd16);

      // STUR X7,[X2,#8]
      fetch_dec(I_STUR, "stur");
      cyc(1'b1, 1'b0, K_K | K_AALU | F_ADD, "stur exec");
      cyc(1'b1, 1'b0, K_AALU | K_RCS | K_K | F_ADD | K_WRR | K_P4, "stur mem ready");
      chk("stur retired", retired, 32'd5);
      chk("stur Const", 32'(Const), 32'd8);

      // CBZ / CBNZ with zero flag set, then B
      fetch_dec(I_CBZ, "cbz");
      cyc(1'b1, 1'b1, K_ALU | K_B | F_ADD | K_POFF, "cbz exec");
      chk("cbz AA", 32'(AA), 32'd31);
      chk("cbz BA", 32'(BA), 32'd9);
      fetch_dec(I_CBNZ, "cbnz");
      cyc(1'b1, 1'b1, K_ALU | K_B | F_ADD | K_P4, "cbnz exec");
      fetch_dec(I_B, "b");
      cyc(1'b1, 1'b0, K_POFF, "b exec");
      chk("b retired", retired, 32'd8);

      // two stalled fetch cycles, then an illegal opcode
      cyc(1'b0, 1'b0, K_FETCH, "fetch stall");
      cyc(1'b0, 1'b0, K_FETCH, "fetch stall");
      fetch_dec(I_BAD, "bad");
      chk("bad illegal", 32'(illegal), 32'd1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 20'h0, "halt idle");
      chk("halt retired", retired, 32'd8);
      chk("halt bus_err", 32'(bus_err), 32'd0);

      // asynchronous reset in HALT
      rst_n = 1'b0; #1;
      chk("async rst ctrl", 32'(ctrl_obs), 32'(K_RESET));
      chk("async rst illegal", 32'(illegal), 32'd0);
      chk("async rst retired", retired, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, K_RESET, "rst state 2");

      // reset while a load waits in MEM: no WR pulse survives
      fetch_dec(I_LDUR, "ldur2");
      cyc(1'b1, 1'b0, K_K | K_AALU | F_ADD, "ldur2 exec");
      cyc(1'b0, 1'b0, K_LDMEM, "ldur2 mem wait");
      mem_ready = 1'b1;
      rst_n = 1'b0; #1;
      chk("mid-mem rst ctrl", 32'(ctrl_obs), 32'(K_RESET));
      @(posedge clk); #1;
      chk("mid-mem rst retired", retired, 32'd0);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, K_RESET, "rst state 3");

      // fetch timeout: bus error on the 15th unanswered cycle
      for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, K_FETCH, "timeout fetch");
      chk("bus_err before limit", 32'(bus_err), 32'd0);
      cyc(1'b0, 1'b0, K_FETCH, "timeout last fetch");
      chk("bus_err at limit", 32'(bus_err), 32'd1);
      cyc(1'b1, 1'b0, 20'h0, "timeout halt");
      rst_n = 1'b0; #1;
      chk("halt rst ctrl", 32'(ctrl_obs), 32'(K_RESET));
      chk("halt rst bus_err", 32'(bus_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
